// File: rtl/zdrain_pkg.sv
// Shared types, constants and address helper for the pulse-counter FIFO drain.
// ZDRAIN_TIMESTAMP_EN selects 4-word entries (lo, hi, frame, pad) instead of 2.
package zdrain_pkg;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BATCH_W = 8;
  localparam int unsigned STATE_W = 4;

`ifdef ZDRAIN_TIMESTAMP_EN
  localparam int unsigned WORDS_PER_ENTRY = 4;
`else
  localparam int unsigned WORDS_PER_ENTRY = 2;
`endif
  localparam int unsigned WORD_SEL_W = $clog2(WORDS_PER_ENTRY);

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POP    = 4'd1;
  localparam logic [3:0] S_LATCH  = 4'd2;
  localparam logic [3:0] S_WR_LO  = 4'd3;
  localparam logic [3:0] S_WR_HI  = 4'd4;
  localparam logic [3:0] S_WR_TS  = 4'd5;
  localparam logic [3:0] S_WR_PAD = 4'd6;
  localparam logic [3:0] S_ADV    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  // base + {entry, word}, modulo 2**ADDR_W
  function automatic logic [ADDR_W-1:0] addr_compose(input logic [ADDR_W-1:0] base,
                                                     input logic [ADDR_W-1:0] entry,
                                                     input logic [1:0]        k);
    logic [ADDR_W-1:0] off;
    off = (entry << WORD_SEL_W) | ADDR_W'(k);
    return base + off;
  endfunction
endpackage

// File: rtl/zpulse_fifo_drain_if.sv
// FIFO read, scheduler grant and SDRAM write signals of the drain block.
interface zpulse_fifo_drain_if;
  import zdrain_pkg::*;

  logic              fifo_is_empty;
  logic              rd_fifo;
  logic [DATA_W-1:0] fifo_data;
  logic              iDrain_Schedule;
  logic              oDrain_Done;
  logic [ADDR_W-1:0] oSDRAM_Wr_Addr;
  logic [WORD_W-1:0] oSDRAM_Wr_Data;
  logic              oSDRAM_Wr_Req;
  logic              iSDRAM_Wr_Done;

  modport master (
    input  fifo_is_empty, fifo_data, iDrain_Schedule, iSDRAM_Wr_Done,
    output rd_fifo, oDrain_Done, oSDRAM_Wr_Addr, oSDRAM_Wr_Data, oSDRAM_Wr_Req
  );

  modport slave (
    output fifo_is_empty, fifo_data, iDrain_Schedule, iSDRAM_Wr_Done,
    input  rd_fifo, oDrain_Done, oSDRAM_Wr_Addr, oSDRAM_Wr_Data, oSDRAM_Wr_Req
  );
endinterface

// File: rtl/zdrain_sdram_wr_port.sv
// Single-word SDRAM write handshake: load addr/data, hold Req until Done, ack.
module zdrain_sdram_wr_port
  import zdrain_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_wr_done,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [WORD_W-1:0] o_data,
  output logic              o_ack_c
);
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;

  // A done pulse only counts while a request is outstanding
  assign o_ack_c = r_req & i_wr_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (o_ack_c) begin
      r_req <= 1'b0;
    end else if (i_load) begin
      r_req  <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end
  end

  assign o_req  = r_req;
  assign o_addr = r_addr;
  assign o_data = r_data;
endmodule

// File: rtl/zpulse_fifo_drain.sv
// Drains pulse-count FIFO entries into an SDRAM ring, one batch per scheduler grant.
// Optional ZDRAIN_TIMESTAMP_EN adds sync_50Hz and a frame-stamp word per entry.
module zpulse_fifo_drain
  import zdrain_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR  = 24'h400000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned BATCH_MAX  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
`ifdef ZDRAIN_TIMESTAMP_EN
  input  logic                  sync_50Hz,
`endif
  zpulse_fifo_drain_if.master   bus,
  output logic [DEPTH_LOG2-1:0] oWr_Ptr,
  output logic                  oWrapped
);
  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic                  r_wrapped;
  logic                  r_rd_fifo;
  logic                  r_done;
  logic [DATA_W-1:0]     r_hold;
  logic [BATCH_W-1:0]    r_batch;
  logic [BATCH_W-1:0]    w_batch_inc;
  logic                  w_in_wr;
  logic                  w_load;
  logic [1:0]            w_word;
  logic [WORD_W-1:0]     w_word_data;
  logic                  w_req;
  logic                  w_ack;
  logic [ADDR_W-1:0]     w_addr;
  logic [WORD_W-1:0]     w_data;

`ifdef ZDRAIN_TIMESTAMP_EN
  logic [WORD_W-1:0] r_frame;
  logic [WORD_W-1:0] r_ts_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame   <= '0;
      r_ts_hold <= '0;
    end else begin
      if (sync_50Hz) r_frame <= r_frame + 1'b1;
      if (r_state == S_LATCH) r_ts_hold <= r_frame;
    end
  end
`endif

  assign w_batch_inc = r_batch + 1'b1;

  // Next state, plus which word of the current entry the write port carries
  always_comb begin
    w_state_nxt = r_state;
    w_in_wr     = 1'b0;
    w_word      = 2'd0;
    w_word_data = r_hold[15:0];
    case (r_state)
      S_IDLE:  if (bus.iDrain_Schedule && en)
                 w_state_nxt = bus.fifo_is_empty ? S_DONE : S_POP;
      S_POP:   w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_WR_LO;
      S_WR_LO: begin
        w_in_wr = 1'b1;
        if (w_ack) w_state_nxt = S_WR_HI;
      end
      S_WR_HI: begin
        w_in_wr     = 1'b1;
        w_word      = 2'd1;
        w_word_data = r_hold[31:16];
`ifdef ZDRAIN_TIMESTAMP_EN
        if (w_ack) w_state_nxt = S_WR_TS;
      end
      S_WR_TS: begin
        w_in_wr     = 1'b1;
        w_word      = 2'd2;
        w_word_data = r_ts_hold;
        if (w_ack) w_state_nxt = S_WR_PAD;
      end
      S_WR_PAD: begin
        w_in_wr     = 1'b1;
        w_word      = 2'd3;
        w_word_data = 16'h0000;
        if (w_ack) w_state_nxt = S_ADV;
      end
`else
        if (w_ack) w_state_nxt = S_ADV;
      end
`endif
      S_ADV:   w_state_nxt = (w_batch_inc == 8'(BATCH_MAX) || bus.fifo_is_empty) ? S_DONE : S_POP;
      S_DONE:  if (!bus.iDrain_Schedule) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Each word gets one idle-Req setup cycle in its state, then one request
  assign w_load = w_in_wr & ~w_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_wrapped <= 1'b0;
      r_rd_fifo <= 1'b0;
      r_done    <= 1'b0;
      r_hold    <= '0;
      r_batch   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_fifo <= (w_state_nxt == S_POP);
      r_done    <= (w_state_nxt == S_DONE);
      if (r_state == S_IDLE)  r_batch <= '0;
      if (r_state == S_LATCH) r_hold  <= bus.fifo_data;
      if (r_state == S_ADV) begin
        r_batch <= w_batch_inc;
        r_ptr   <= r_ptr + 1'b1;
        if (&r_ptr) r_wrapped <= 1'b1;
      end
    end
  end

  zdrain_sdram_wr_port u_wr_port (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_addr    (addr_compose(BASE_ADDR, ADDR_W'(r_ptr), w_word)),
    .i_data    (w_word_data),
    .i_wr_done (bus.iSDRAM_Wr_Done),
    .o_req     (w_req),
    .o_addr    (w_addr),
    .o_data    (w_data),
    .o_ack_c   (w_ack)
  );

  assign bus.rd_fifo        = r_rd_fifo;
  assign bus.oDrain_Done    = r_done;
  assign bus.oSDRAM_Wr_Req  = w_req;
  assign bus.oSDRAM_Wr_Addr = w_addr;
  assign bus.oSDRAM_Wr_Data = w_data;
  assign oWr_Ptr            = r_ptr;
  assign oWrapped           = r_wrapped;
endmodule
